// File: rtl/stream_muxn.sv
// stream_muxn: N-channel valid/ready stream multiplexer with one output register.
//
// Two arbitration modes:
//   mode = 0  fixed-select: the channel named by sel is the source.
//   mode = 1  round-robin: search starts at the channel after the last one served.
// The round-robin pointer moves on every input transfer in both modes, so a
// switch to round-robin continues fairly from the last channel served.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   in_data     flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready (one-hot or zero)
//   mode        0 = fixed-select, 1 = round-robin
//   sel         source channel in fixed-select mode
//   out_data    registered output data
//   out_ch      channel that supplied out_data
//   out_valid   output register holds an unconsumed beat
//   out_ready   consumer accepts the beat
//   xfer_count  saturating count of output transfers
//
// Build option: define STREAM_MUXN_STATS_EN to implement xfer_count;
// otherwise xfer_count is tied to zero.

module stream_muxn #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_count
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             take;

    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
        return SEL_W'((int'(base) + k) % NUM_CH);
    endfunction

    assign load_en = ~out_valid | out_ready;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode) begin
            grant_valid = |in_valid;
            // Scan from the farthest offset down so the nearest valid channel
            // after rr_ptr is the last assignment and therefore wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                if (in_valid[rr_idx(rr_ptr, k)]) grant = rr_idx(rr_ptr, k);
            end
        end else begin
            grant = sel;
            // Out-of-range select (non-power-of-2 channel count) never grants.
            if (int'(sel) < NUM_CH) grant_valid = in_valid[sel];
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && load_en && grant_valid) in_ready[grant] = 1'b1;
    end

    assign take = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            // With no new beat the register empties; data and channel hold.
            out_valid <= take;
            if (take) begin
                out_data <= grant_data;
                out_ch   <= grant;
                rr_ptr   <= grant;
            end
        end
    end

`ifdef STREAM_MUXN_STATS_EN
    logic [15:0] xfer_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && xfer_cnt != 16'hFFFF) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign xfer_count = xfer_cnt;
`else
    assign xfer_count = 16'h0000;
`endif

endmodule

// File: doc/stream_muxn.md
Name: stream_muxn

Overview:
- Parametrised successor to the fixed 4-way 16-bit selector: N channels of WIDTH bits, each with a valid/ready handshake, merged into one registered output stream.
- Two modes: fixed-select, where the `sel` port picks the source, and round-robin arbitration across all valid channels.
- Sits between multiple Hack data producers (e.g. memory-mapped peripherals, DMA sources) and a single consumer (bus or CPU-side port).
- One output register stage.

Parameters:
- WIDTH, 16, data width per channel.
- NUM_CH, 4, number of input channels; must be ≥ 2.
- SEL_W, derived as clog2(NUM_CH) via localparam (not user-settable), width of select and channel-ID fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = fixed-select, 1 = round-robin.
- sel  in  SEL_W  source channel in fixed-select mode; ignored in round-robin mode.
- out_data  out  WIDTH  registered output data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output holds an unconsumed beat.
- out_ready  in  1  consumer accepts the beat.
- xfer_count  out  16  accepted-output-beat counter (see Optional Feature).

Behaviour:
- Reset, synchronous: out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, xfer_count=0. in_ready is all-zero during reset cycles. A beat in flight at reset is dropped.
- load_en = ~out_valid | out_ready. The output register accepts a new beat when empty, or when the current beat drains in the same cycle. This gives full throughput: 1 beat/cycle.
- Grant is combinational from current inputs:
  - Fixed mode: grant=sel; grant_valid = (sel < NUM_CH) & in_valid[sel]. An out-of-range sel (non-power-of-2 NUM_CH) never grants.
  - Round-robin mode: grant = first i with in_valid[i], scanning rr_ptr+1, rr_ptr+2, … modulo NUM_CH; grant_valid = |in_valid.
- in_ready[i] = load_en & grant_valid & (grant==i). Must not depend on in_valid[i] of other channels beyond the grant computation. No combinational path from in_valid to in_ready of the same channel beyond the grant.
- Input transfer on channel i = in_valid[i] & in_ready[i]. On transfer, the next cycle has out_data=channel i data, out_ch=i, out_valid=1.
- rr_ptr updates to the granted index on every input transfer, in both modes. Switching to round-robin therefore continues fairly after the last served channel.
- Output transfer = out_valid & out_ready. If load_en is true but there is no input transfer, out_valid falls to 0. out_data and out_ch hold their last value.
- While out_valid=1 & out_ready=0, out_data/out_ch/out_valid are stable and all in_ready=0. This is the AXI-style no-retract rule on the output side.
- Latency: input transfer in cycle n gives out_valid in cycle n+1.
- Changes to mode or sel mid-stream affect only the next grant decision; a held output beat is never altered.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,…,NUM_CH-1,0,… with no channel starved longer than NUM_CH-1 beats.

Optional Feature:
- Macro: STREAM_MUXN_STATS_EN.
- Defined: xfer_count increments by 1 on each output transfer and saturates at 16'hFFFF; it is cleared by reset.
- Undefined: xfer_count is tied to 16'h0000 and no counter logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with all in_valid=1, then hold reset 2 cycles → in_ready=0 and out_valid=0 throughout; out_data=0. After release, first grant is channel 0 in round-robin mode.
- Fixed mode, sel=2, in_valid=4'b1111, ch2 data=16'hBEEF, out_ready=1 → only in_ready[2]=1; next cycle out_data=16'hBEEF, out_ch=2. Streams 1 beat/cycle.
- Round-robin, in_valid=4'b1111 constant, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3.
- Round-robin, in_valid=4'b1010 → out_ch alternates 1,3,1,3. Drop ch3 valid → only 1 thereafter.
- Backpressure: out_ready=0 for 3 cycles with a beat held → out_data stable, all in_ready=0. Assert out_ready → drain and new beat loaded in the same cycle, out_valid stays 1.
- STREAM_MUXN_STATS_EN defined: 5 output transfers → xfer_count=5. Preload near saturation via 65540 transfers → xfer_count=16'hFFFF. Undefined build → xfer_count=0 always.
